wr_control: RTL and testbench

//   Output-side write controller for the systolic array. It mirrors the input-side read controller.

---
 rtl/wr_control_if.sv | 14 +
 rtl/wr_control.sv | 78 +++++++
 tb/tb_wr_control.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/wr_control_if.sv
// wr_control_if: start/base-address request and per-lane write-enable/address bundle for wr_control.
interface wr_control_if #(
   parameter int WIDTH_HEIGHT = 16,
   parameter int ADDR_WIDTH   = 8
);
   logic                               active;
   logic [ADDR_WIDTH-1:0]              base_addr;
   logic [WIDTH_HEIGHT-1:0]            wr_en;
   logic [WIDTH_HEIGHT*ADDR_WIDTH-1:0] wr_addr;
   logic                               busy;
   logic                               done;
   modport master (output active, base_addr, input wr_en, wr_addr, busy, done);
   modport slave  (input active, base_addr, output wr_en, wr_addr, busy, done);
endinterface

// File: rtl/wr_control.sv
// wr_control: skewed write-enable staircase with per-lane write addresses for the systolic array output side.
module wr_control #(
   parameter int WIDTH_HEIGHT = 16,
   parameter int ADDR_WIDTH   = 8
) (
   input logic        clk,
   input logic        reset,
   wr_control_if.slave bus
);
   localparam int W  = WIDTH_HEIGHT;
   localparam int A  = ADDR_WIDTH;
   localparam int CW = $clog2(2 * W) + 1;
   typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;
   state_t         state, state_n;
   logic [W-1:0]   en_q, en_n;
   logic [W*A-1:0] addr_q, addr_n, addr_inc;
   logic [CW-1:0]  cnt_q, cnt_n;
   logic           done_q, done_n;
   always_comb begin
      addr_inc = '0;
      for (int i = 0; i < W; i++)
         addr_inc[i*A +: A] = addr_q[i*A +: A] + {{(A-1){1'b0}}, en_q[i]};
   end
   always_comb begin
      state_n = state;
      en_n    = en_q;
      addr_n  = addr_q;
      cnt_n   = cnt_q;
      done_n  = 1'b0;
      case (state)
         IDLE: begin
            en_n   = bus.active ? {{(W-1){1'b0}}, 1'b1} : '0;
            addr_n = bus.active ? {W{bus.base_addr}} : '0;
            cnt_n  = bus.active ? CW'(1) : '0;
            state_n = bus.active ? FILL : IDLE;
         end
         FILL: begin
            // once every lane is on, start draining from lane 0
            addr_n  = addr_inc;
            en_n    = {en_q[W-2:0], cnt_q != CW'(W)};
            cnt_n   = (cnt_q == CW'(W)) ? cnt_q : cnt_q + 1'b1;
            state_n = (cnt_q == CW'(W)) ? DRAIN : FILL;
         end
         DRAIN: begin
            if (en_q == {1'b1, {(W-1){1'b0}}}) begin
               en_n    = '0;
               addr_n  = '0;
               cnt_n   = '0;
               done_n  = 1'b1;
               state_n = DONE;
            end else begin
               en_n   = {en_q[W-2:0], 1'b0};
               addr_n = addr_inc;
            end
         end
         DONE: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         en_q   <= '0;
         addr_q <= '0;
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         state  <= state_n;
         en_q   <= en_n;
         addr_q <= addr_n;
         cnt_q  <= cnt_n;
         done_q <= done_n;
      end
   end
   assign bus.wr_en   = en_q;
   assign bus.wr_addr = addr_q;
   assign bus.busy    = (state != IDLE);
   assign bus.done    = done_q;
endmodule

// File: tb/tb_wr_control.sv
// tb_wr_control: scoreboard bench for wr_control at W=16 and W=4; expected staircases come from the
// closed-form timing (lane i enabled on cycles i..i+W-1 with address base+(k-i), done at 2W-1).
module tb_wr_control;
   typedef struct {
      int           cyc;
      logic [15:0]  en;
      logic [127:0] addr;
      logic         done;
   } rec_t;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;
   bit   fin = 1'b0;
   bit   fin_chk = 1'b0;
   rec_t q16[$];
   rec_t q4[$];
   int   zq[$];
   rec_t e;
   wr_control_if #(.WIDTH_HEIGHT(16), .ADDR_WIDTH(8)) i16();
   wr_control_if #(.WIDTH_HEIGHT(4),  .ADDR_WIDTH(8)) i4();
   wr_control #(.WIDTH_HEIGHT(16), .ADDR_WIDTH(8)) u16 (.clk(clk), .reset(reset), .bus(i16));
   wr_control #(.WIDTH_HEIGHT(4),  .ADDR_WIDTH(8)) u4  (.clk(clk), .reset(reset), .bus(i4));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   function automatic void push_run(input int w, input int st, input logic [7:0] b, input int nrec);
      rec_t r;
      for (int k = 0; k < nrec; k++) begin
         r.cyc  = st + k;
         r.en   = '0;
         r.addr = '0;
         r.done = (k == 2 * w - 1);
         for (int i = 0; i < w; i++)
            if (k >= i && k < i + w) begin
               r.en[i] = 1'b1;
               r.addr[i*8 +: 8] = b + 8'(k - i);
            end
         if (w == 16) q16.push_back(r);
         else q4.push_back(r);
      end
   endfunction
   function automatic bit bad(input rec_t x, input int c, input logic [15:0] en,
                              input logic [127:0] a, input logic dn, input logic bz);
      bit m;
      m = (c != x.cyc) || (en !== x.en) || (dn !== x.done) || (bz !== 1'b1);
      for (int i = 0; i < 16; i++)
         if (x.en[i] || x.done) m = m | (a[i*8 +: 8] !== x.addr[i*8 +: 8]);
      return m;
   endfunction
   always @(negedge clk) begin
      if (((|i16.wr_en) === 1'b1) || (i16.done === 1'b1)) begin
         tests++;
         if (q16.size() == 0) begin
            fails++;
            $display("FAIL w16_unexpected cyc=%0d got en=%h done=%b, required no output", cyc, i16.wr_en, i16.done);
         end else begin
            e = q16.pop_front();
            if (bad(e, cyc, i16.wr_en, i16.wr_addr, i16.done, i16.busy)) begin
               fails++;
               $display("FAIL w16_out got cyc=%0d en=%h done=%b busy=%b addr=%h, required cyc=%0d en=%h done=%b busy=1 addr=%h",
                        cyc, i16.wr_en, i16.done, i16.busy, i16.wr_addr, e.cyc, e.en, e.done, e.addr);
            end
         end
      end
      if (((|i4.wr_en) === 1'b1) || (i4.done === 1'b1)) begin
         tests++;
         if (q4.size() == 0) begin
            fails++;
            $display("FAIL w4_unexpected cyc=%0d got en=%h done=%b, required no output", cyc, i4.wr_en, i4.done);
         end else begin
            e = q4.pop_front();
            if (bad(e, cyc, {12'b0, i4.wr_en}, {96'b0, i4.wr_addr}, i4.done, i4.busy)) begin
               fails++;
               $display("FAIL w4_out got cyc=%0d en=%h done=%b busy=%b addr=%h, required cyc=%0d en=%h done=%b busy=1 addr=%h",
                        cyc, i4.wr_en, i4.done, i4.busy, i4.wr_addr, e.cyc, e.en[3:0], e.done, e.addr[31:0]);
            end
         end
      end
      if (zq.size() != 0 && zq[0] <= cyc) begin
         void'(zq.pop_front());
         tests++;
         if ({i16.wr_en, i16.wr_addr, i16.busy, i16.done, i4.wr_en, i4.wr_addr, i4.busy, i4.done} !== '0) begin
            fails++;
            $display("FAIL idle_zero cyc=%0d got en16=%h addr16=%h busy16=%b done16=%b en4=%h addr4=%h busy4=%b done4=%b, required all 0",
                     cyc, i16.wr_en, i16.wr_addr, i16.busy, i16.done, i4.wr_en, i4.wr_addr, i4.busy, i4.done);
         end
      end
      if (fin && !fin_chk) begin
         fin_chk = 1'b1;
         tests++;
         if (q16.size() != 0 || q4.size() != 0 || zq.size() != 0) begin
            fails++;
            $display("FAIL leftover got pending w16=%0d w4=%0d zero=%0d, required 0 0 0", q16.size(), q4.size(), zq.size());
         end
      end
   end
   task automatic start(input int w, input logic [7:0] b, input int nrec);
      push_run(w, cyc + 1, b, nrec);
      if (w == 16) begin
         i16.base_addr = b;
         i16.active = 1'b1;
      end else begin
         i4.base_addr = b;
         i4.active = 1'b1;
      end
      @(negedge clk);
      i16.active = 1'b0;
      i4.active = 1'b0;
   endtask
   task automatic reset_mid(input int w, input logic [7:0] b, input int n);
      start(w, b, n);
      repeat (n - 1) @(negedge clk);
      reset = 1'b1;
      zq.push_back(cyc + 1);
      @(negedge clk);
      reset = 1'b0;
   endtask
   initial begin
      i16.active = 1'b0;
      i16.base_addr = '0;
      i4.active = 1'b0;
      i4.base_addr = '0;
      zq.push_back(1);
      zq.push_back(2);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      reset_mid(16, 8'($urandom_range(255)), 7);
      start(16, 8'h10, 32);
      zq.push_back(cyc + 32);
      repeat (32) @(negedge clk);
      push_run(16, cyc + 1, 8'h55, 32);
      push_run(16, cyc + 34, 8'h55, 32);
      i16.base_addr = 8'h55;
      i16.active = 1'b1;
      repeat (66) @(negedge clk);
      i16.active = 1'b0;
      zq.push_back(cyc + 1);
      @(negedge clk);
      start(16, 8'hF8, 32);
      repeat (32) @(negedge clk);
      reset_mid(16, 8'h80, 21);
      start(16, 8'h00, 32);
      repeat (32) @(negedge clk);
      start(4, 8'h30, 8);
      i4.base_addr = 8'hAA;
      repeat (8) @(negedge clk);
      start(4, 8'hFE, 8);
      zq.push_back(cyc + 8);
      repeat (10) @(negedge clk);
      fin = 1'b1;
      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
